// File: rtl/p2s_pkg.sv
// Shared definitions for the serial display driver: FSM encoding,
// default parameter values and a counter-width helper.
package p2s_pkg;

    localparam int P2S_WIDTH   = 16;
    localparam int P2S_CLK_DIV = 4;
    localparam bit P2S_INVERT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } p2s_state_e;

    // Counter width that stays legal when the terminal count is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p2s_tick_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles, restartable
// so every frame begins on a fresh half-period.
module p2s_tick_gen
    import p2s_pkg::*;
#(
    parameter int CLK_DIV = P2S_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = cnt_w(CLK_DIV);
    localparam logic [CW-1:0]  TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_display_driver.sv
// Parallel-to-serial LED driver: shifts a pattern MSB first to an external
// shift register, then latches it; refreshes only when the pattern changes.
module serial_display_driver
    import p2s_pkg::*;
#(
    parameter int WIDTH   = P2S_WIDTH,
    parameter int CLK_DIV = P2S_CLK_DIV,
    parameter bit INVERT  = P2S_INVERT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             led_en,
    output logic             busy,
    output logic             finish,
    output logic             led_clk,
    output logic             led_dat,
    output logic             led_pen
);

    localparam int            BW       = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    p2s_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] sent_q,  sent_d;
    logic             dirty_q, dirty_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic             phase_q, phase_d;
    logic             pen_q,   pen_d;
    logic             start;
    logic             tick;

    p2s_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .tick (tick)
    );

    assign start = (state_q == ST_IDLE) && led_en && (dirty_q || (data != sent_q));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sent_d  = sent_q;
        dirty_d = dirty_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        pen_d   = pen_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    shreg_d = INVERT ? ~data : data;
                    sent_d  = data;
                    dirty_d = 1'b0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    pen_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                // phase 0 = led_clk low (data settling), phase 1 = led_clk high
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = ST_LATCH;
                            pen_d   = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                        end
                    end
                end
            end
            ST_LATCH: if (tick) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            sent_q  <= '0;
            dirty_q <= 1'b1;
            bit_q   <= '0;
            phase_q <= 1'b0;
            pen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            sent_q  <= sent_d;
            dirty_q <= dirty_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            pen_q   <= pen_d;
        end
    end

    // Outputs decode registered state only; inputs never reach them directly.
    assign busy    = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
    assign finish  = (state_q == ST_DONE);
    assign led_clk = (state_q == ST_SHIFT) && phase_q;
    assign led_dat = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    assign led_pen = pen_q;

endmodule

// File: tb/tb_serial_display_driver.sv
// Scoreboard bench: a frame-level model predicts each frame's bit pattern and
// finish cycle; a monitor reconstructs frames from led_clk/led_dat and compares.
module tb_serial_display_driver;

    localparam int W  = 16;
    localparam int CD = 2;
    localparam int L  = 2*CD*W + CD + 1;

    typedef struct {
        logic [W-1:0] pat;
        int           fin;
    } exp_t;

    logic         clk, rst, led_en;
    logic [W-1:0] data;
    logic         busy_w [2];
    logic         finish_w [2];
    logic         led_clk_w [2];
    logic         led_dat_w [2];
    logic         led_pen_w [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];

    serial_display_driver #(.WIDTH(W), .CLK_DIV(CD), .INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .data(data), .led_en(led_en),
        .busy(busy_w[0]), .finish(finish_w[0]), .led_clk(led_clk_w[0]),
        .led_dat(led_dat_w[0]), .led_pen(led_pen_w[0])
    );

    serial_display_driver #(.WIDTH(W), .CLK_DIV(CD), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .data(data), .led_en(led_en),
        .busy(busy_w[1]), .finish(finish_w[1]), .led_clk(led_clk_w[1]),
        .led_dat(led_dat_w[1]), .led_pen(led_pen_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: a refresh starts whenever the driver is free, enabled
    // and the pattern differs from the last one sent (or after reset).
    logic [W-1:0] m_sent;
    logic         m_dirty;
    int           m_free_at;

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            m_sent    = '0;
            m_dirty   = 1'b1;
            m_free_at = cyc + 1;
            q0.delete();
            q1.delete();
        end else if (cyc >= m_free_at && led_en && (m_dirty || data != m_sent)) begin
            e.fin = cyc + L - 1;
            e.pat = data;
            q0.push_back(e);
            e.pat = ~data;
            q1.push_back(e);
            m_sent    = data;
            m_dirty   = 1'b0;
            m_free_at = cyc + L + 1;
        end
    end

    // Monitor: rebuild the shifted word from led_clk rising edges.
    logic         pbusy [2];
    logic         pclk  [2];
    logic [W-1:0] bits  [2];
    int           nb    [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            pbusy[k] = 1'b0; pclk[k] = 1'b0; bits[k] = '0; nb[k] = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic have;
        for (int k = 0; k < 2; k++) begin
            if (busy_w[k] && !pbusy[k]) begin
                bits[k] = '0;
                nb[k]   = 0;
            end
            if (led_clk_w[k] && !pclk[k]) begin
                bits[k] = {bits[k][W-2:0], led_dat_w[k]};
                nb[k]++;
                chk("pen_low_in_shift", {31'd0, led_pen_w[k]}, 32'd0);
            end
            if (finish_w[k]) begin
                have = 1'b0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                chk("finish_expected", {31'd0, have}, 32'd1);
                if (have) begin
                    chk("frame_bits", {16'd0, bits[k]}, {16'd0, e.pat});
                    chk("frame_nbits", nb[k], W);
                    chk("finish_cycle", cyc, e.fin);
                    chk("pen_at_finish", {31'd0, led_pen_w[k]}, 32'd1);
                    chk("idle_lines_at_finish", {30'd0, led_clk_w[k], led_dat_w[k]}, 32'd0);
                end
            end
            pbusy[k] = busy_w[k];
            pclk[k]  = led_clk_w[k];
        end
    end

    task automatic wait_busy(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (busy_w[0] !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, busy_w[0]}, {31'd0, lvl});
    endtask

    task automatic chk_reset_outs(input string nm);
        for (int k = 0; k < 2; k++)
            chk(nm, {27'd0, busy_w[k], finish_w[k], led_clk_w[k], led_dat_w[k], led_pen_w[k]}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] r;
        rst    = 1'b1;
        led_en = 1'b1;
        data   = 16'hA5C3;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_outputs");
        rst = 1'b0;

        // First frame straight out of reset
        wait_busy(1'b1, 5, "a5c3_start");
        wait_busy(1'b0, L + 5, "a5c3_end");
        @(negedge clk);
        chk("pen_after_frame", {31'd0, led_pen_w[0]}, 32'd1);

        // Constant pattern: a single refresh, then quiet
        data = 16'h00FF;
        wait_busy(1'b1, 5, "00ff_start");
        wait_busy(1'b0, L + 5, "00ff_end");
        repeat (300) @(negedge clk);
        chk("hold_idle", {31'd0, busy_w[0]}, 32'd0);
        chk("hold_no_pending", q0.size(), 0);

        // Pattern change mid-frame is deferred to the following frame
        data = 16'h1234;
        wait_busy(1'b1, 5, "1234_start");
        repeat (10) @(negedge clk);
        data = 16'h8001;
        wait_busy(1'b0, L + 5, "1234_end");
        wait_busy(1'b1, 5, "8001_start");
        wait_busy(1'b0, L + 5, "8001_end");

        // Reset mid-frame aborts with no finish
        data = 16'h5A5A;
        wait_busy(1'b1, 5, "5a5a_start");
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs("abort_outputs");
        rst = 1'b0;
        wait_busy(1'b1, 5, "post_abort_start");
        wait_busy(1'b0, L + 5, "post_abort_end");

        // Enable dropped mid-frame: frame completes, nothing new starts
        data = 16'h0F0F;
        wait_busy(1'b1, 5, "0f0f_start");
        repeat (5) @(negedge clk);
        led_en = 1'b0;
        r = 16'($urandom);
        if (r == 16'h0F0F || r == 16'hFFFF) r = 16'h0001;
        data = r;
        wait_busy(1'b0, L + 5, "0f0f_end");
        repeat (200) @(negedge clk);
        chk("disabled_idle", {31'd0, busy_w[0]}, 32'd0);
        chk("disabled_no_pending", q0.size(), 0);
        led_en = 1'b1;
        wait_busy(1'b1, 5, "resume_start");
        wait_busy(1'b0, L + 5, "resume_end");

        // All-ones pattern (inverted instance shifts all zeros)
        data = 16'hFFFF;
        wait_busy(1'b1, 5, "ffff_start");
        wait_busy(1'b0, L + 5, "ffff_end");
        @(negedge clk);
        chk("inv_pen_after", {31'd0, led_pen_w[1]}, 32'd1);

        // Randomized pattern/enable churn
        for (int i = 0; i < 25; i++) begin
            data   = 16'($urandom);
            led_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 120)) @(negedge clk);
        end

        led_en = 1'b0;
        repeat (L + 20) @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
